// File: rtl/freq_step_controller.sv
// Key-driven reference frequency stepper: up/down/step/preset pulses sampled only in IDLE.
// One-cycle command latency; a new freq_hz is held under upd_valid until upd_ready, then a lockout ignores keys.
module freq_step_controller #(
    parameter int FREQ_MIN       = 20,
    parameter int FREQ_MAX       = 20000,
    parameter int FREQ_INIT      = 1000,
    parameter int LOCKOUT_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pulse_in,
    input  logic        upd_ready,
    output logic [15:0] freq_hz,
    output logic [1:0]  step_sel,
    output logic        upd_valid,
    output logic        busy,
    output logic        at_limit
);

    localparam int              CNT_W         = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOCK_LOAD    = CNT_W'(LOCKOUT_CYCLES);
    localparam logic            LOCK_EN       = (LOCKOUT_CYCLES != 0);
    localparam logic [15:0]     F_MIN         = 16'(FREQ_MIN);
    localparam logic [15:0]     F_MAX         = 16'(FREQ_MAX);
    localparam logic [15:0]     F_INIT        = 16'(FREQ_INIT);
    localparam logic            INIT_AT_LIMIT = (FREQ_INIT == FREQ_MIN) || (FREQ_INIT == FREQ_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_UPDATE  = 2'd1,
        S_LOCKOUT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_freq;
    logic [15:0]      w_freq_nxt;
    logic [1:0]       r_step;
    logic [1:0]       w_step_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_busy;
    logic             r_at_limit;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [15:0]      w_step_val;
    logic [16:0]      w_sum;
    logic [16:0]      w_dn_floor;
    logic [15:0]      w_freq_up;
    logic [15:0]      w_freq_dn;

    always_comb begin
        w_step_val = 16'd1;
        case (r_step)
            2'd0: w_step_val = 16'd1;
            2'd1: w_step_val = 16'd10;
            2'd2: w_step_val = 16'd100;
            2'd3: w_step_val = 16'd1000;
            default: w_step_val = 16'd1;
        endcase
    end

    // Arithmetic is done at 17 bits so saturation is decided before any wrap.
    assign w_sum      = {1'b0, r_freq} + {1'b0, w_step_val};
    assign w_dn_floor = {1'b0, F_MIN} + {1'b0, w_step_val};
    assign w_freq_up  = (w_sum > {1'b0, F_MAX}) ? F_MAX : w_sum[15:0];
    assign w_freq_dn  = ({1'b0, r_freq} < w_dn_floor) ? F_MIN : (r_freq - w_step_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        w_step_nxt  = r_step;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (pulse_in[3]) begin
                    w_freq_nxt  = F_INIT;
                    w_step_nxt  = 2'd0;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_UPDATE;
                end else if (pulse_in[2]) begin
                    w_step_nxt = r_step + 2'd1;
                    if (LOCK_EN) begin
                        w_state_nxt = S_LOCKOUT;
                        w_cnt_nxt   = LOCK_LOAD;
                    end
                end else if (pulse_in[1]) begin
                    w_freq_nxt  = w_freq_dn;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_UPDATE;
                end else if (pulse_in[0]) begin
                    w_freq_nxt  = w_freq_up;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (upd_ready) begin
                    w_valid_nxt = 1'b0;
                    if (LOCK_EN) begin
                        w_state_nxt = S_LOCKOUT;
                        w_cnt_nxt   = LOCK_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_LOCKOUT: begin
                // Counter holds the cycles left including this one, so the lockout spans exactly LOCKOUT_CYCLES.
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_freq     <= F_INIT;
            r_step     <= 2'd0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_at_limit <= INIT_AT_LIMIT;
        end else begin
            r_freq     <= w_freq_nxt;
            r_step     <= w_step_nxt;
            r_valid    <= w_valid_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_cnt      <= w_cnt_nxt;
            r_at_limit <= (w_freq_nxt == F_MIN) || (w_freq_nxt == F_MAX);
        end
    end

    assign freq_hz   = r_freq;
    assign step_sel  = r_step;
    assign upd_valid = r_valid;
    assign busy      = r_busy;
    assign at_limit  = r_at_limit;

endmodule
